// File: rtl/rr_grant_sequencer_pkg.sv
// Shared definitions for the round-robin grant sequencer: FSM state
// encodings and the hold-counter width helper.
package rr_grant_sequencer_pkg;

  // 2-bit state encodings; 2'b11 is unreachable in normal operation.
  localparam logic [1:0] ST_IDLE    = 2'b00;
  localparam logic [1:0] ST_GRANT   = 2'b01;
  localparam logic [1:0] ST_REVOKE  = 2'b10;
  localparam logic [1:0] ST_ILLEGAL = 2'b11;

  // Hold counter must represent 0..MAX_HOLD-1 with one bit of headroom so an
  // over-range value (fault) stays visible to the safety flag.
  function automatic int hold_cnt_width(input int max_hold);
    return $clog2(max_hold) + 1;
  endfunction

endpackage

// File: rtl/rr_grant_sequencer_pick.sv
// Rotating priority encoder: returns the first requester with req set,
// scanning ptr, ptr+1, ... wrapping at N_REQ.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             any,
  output logic [ID_W-1:0]  idx
);

  int w_sum;

  // Scan from the farthest slot down to ptr so the slot closest to ptr
  // is written last and therefore wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first;
    // a path that leaves one unassigned would infer a latch.
    any   = 1'b0;
    idx   = '0;
    w_sum = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_sum = int'(ptr) + k;
      if (w_sum >= N_REQ) w_sum = w_sum - N_REQ;
      if (req[w_sum]) begin
        any = 1'b1;
        idx = ID_W'(w_sum);
      end
    end
  end

endmodule

// File: rtl/rr_grant_sequencer.sv
// Round-robin grant sequencer for one shared resource. Grants are held
// until released (done or req drop on the owner) or until MAX_HOLD cycles
// elapse, then a revoke cycle drains the resource before the next grant.
// `bad` flags any state that must be unreachable.
module rr_grant_sequencer
  import rr_grant_sequencer_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int ID_W     = $clog2(N_REQ),
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_vld,
  output logic             timeout,
  output logic             bad
);

  localparam int               HC_W      = hold_cnt_width(MAX_HOLD);
  localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(MAX_HOLD - 1);
  localparam logic [ID_W-1:0]  ID_LAST   = ID_W'(N_REQ - 1);

  logic [1:0]       r_state;
  logic [N_REQ-1:0] r_gnt;
  logic [ID_W-1:0]  r_gnt_id;
  logic             r_gnt_vld;
  logic             r_timeout;
  logic [ID_W-1:0]  r_ptr;
  logic [HC_W-1:0]  r_hold_cnt;

  logic             w_any;
  logic [ID_W-1:0]  w_idx;
  logic             w_release;
  logic             w_limit;
  logic [ID_W-1:0]  w_next_ptr;
  logic             w_multi_gnt;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req (req),
    .ptr (r_ptr),
    .any (w_any),
    .idx (w_idx)
  );

  // Only the current owner's done/req bits matter; others are ignored.
  assign w_release  = done[r_gnt_id] | ~req[r_gnt_id];
  assign w_limit    = (r_hold_cnt >= HOLD_LAST);
  assign w_next_ptr = (r_gnt_id == ID_LAST) ? '0 : r_gnt_id + ID_W'(1);

  // Grant/hold/revoke sequencing with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_gnt      <= '0;
      r_gnt_id   <= '0;
      r_gnt_vld  <= 1'b0;
      r_timeout  <= 1'b0;
      r_ptr      <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state    <= ST_GRANT;
            r_gnt      <= N_REQ'(1) << w_idx;
            r_gnt_id   <= w_idx;
            r_gnt_vld  <= 1'b1;
            r_hold_cnt <= '0;
          end
        end
        ST_GRANT: begin
          if (w_release || w_limit) begin
            // Normal release takes precedence over the hold limit.
            r_state    <= ST_REVOKE;
            r_gnt      <= '0;
            r_gnt_vld  <= 1'b0;
            r_ptr      <= w_next_ptr;
            r_hold_cnt <= '0;
            r_timeout  <= ~w_release;
          end else if (r_hold_cnt != HOLD_LAST) begin
            r_hold_cnt <= r_hold_cnt + HC_W'(1);
          end
        end
        ST_REVOKE: begin
          // Dead cycle so the resource drains before the next grant.
          r_state <= ST_IDLE;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_gnt      <= '0;
          r_gnt_vld  <= 1'b0;
          r_hold_cnt <= '0;
        end
      endcase
    end
  end

  assign w_multi_gnt = |(r_gnt & (r_gnt - N_REQ'(1)));

  assign bad = (r_state == ST_ILLEGAL)
             | w_multi_gnt
             | (r_gnt_vld != |r_gnt)
             | (r_gnt_vld & (r_state != ST_GRANT))
             | (r_hold_cnt > HOLD_LAST);

  assign gnt     = r_gnt;
  assign gnt_id  = r_gnt_id;
  assign gnt_vld = r_gnt_vld;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_rr_grant_sequencer.sv
// Self-checking bench for rr_grant_sequencer: directed scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_rr_grant_sequencer;

  localparam int N_REQ    = 4;
  localparam int ID_W     = 2;
  localparam int MAX_HOLD = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [N_REQ-1:0] req = '0;
  logic [N_REQ-1:0] done = '0;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_vld;
  logic             timeout;
  logic             bad;

  rr_grant_sequencer #(
    .N_REQ    (N_REQ),
    .ID_W     (ID_W),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld),
    .timeout (timeout),
    .bad     (bad)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: who owns the resource, how many cycles the grant has been
  // visible, and where the next round-robin scan starts.
  bit m_owned;
  bit m_draining;
  int m_owner;
  int m_ptr;
  int m_held;
  bit m_timeout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_step(input logic r, input logic [N_REQ-1:0] rq, input logic [N_REQ-1:0] dn);
    int i;
    m_timeout = 1'b0;
    if (!r) begin
      m_owned = 0; m_draining = 0; m_owner = 0; m_ptr = 0; m_held = 0;
      return;
    end
    if (m_draining) begin
      m_draining = 0;
    end else if (m_owned) begin
      if (dn[m_owner[ID_W-1:0]] || !rq[m_owner[ID_W-1:0]]) begin
        m_owned = 0; m_draining = 1; m_ptr = (m_owner + 1) % N_REQ;
      end else if (m_held == MAX_HOLD) begin
        m_owned = 0; m_draining = 1; m_timeout = 1'b1; m_ptr = (m_owner + 1) % N_REQ;
      end else begin
        m_held++;
      end
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        i = (m_ptr + k) % N_REQ;
        if (rq[i[ID_W-1:0]]) begin
          m_owned = 1; m_owner = i; m_held = 1;
          break;
        end
      end
    end
  endtask

  // One clock: drive at negedge, model at posedge, compare just after.
  task automatic step(input logic r, input logic [N_REQ-1:0] rq, input logic [N_REQ-1:0] dn);
    @(negedge clk);
    reset = r; req = rq; done = dn;
    @(posedge clk);
    model_step(r, rq, dn);
    #1;
    check("gnt", 32'(gnt), m_owned ? (32'(1) << m_owner) : 32'(0));
    check("gnt_vld", 32'(gnt_vld), 32'(m_owned));
    check("timeout", 32'(timeout), 32'(m_timeout));
    check("bad", 32'(bad), 32'(0));
    if (m_owned) check("gnt_id", 32'(gnt_id), 32'(m_owner));
  endtask

  initial begin
    logic             r_rand;
    logic [N_REQ-1:0] rq_rand;
    logic [N_REQ-1:0] dn_rand;

    // Reset held low with all requests asserted.
    for (int c = 0; c < 3; c++) step(1'b0, 4'b1111, 4'b0000);
    check("rst_gnt", 32'(gnt), 32'(0));
    check("rst_gnt_id", 32'(gnt_id), 32'(0));

    // Single requester 2, release via done, pointer moves to 3.
    step(1'b1, 4'b0100, 4'b0000);
    check("t2_gnt", 32'(gnt), 32'h4);
    check("t2_gnt_id", 32'(gnt_id), 32'd2);
    step(1'b1, 4'b0100, 4'b0000);
    step(1'b1, 4'b0100, 4'b0100);
    check("t2_revoke", 32'(gnt_vld), 32'(0));
    step(1'b1, 4'b1111, 4'b0000);
    check("t2_dead", 32'(gnt_vld), 32'(0));
    step(1'b1, 4'b1111, 4'b0000);
    check("t2_ptr3", 32'(gnt_id), 32'd3);

    // All requesting, done each grant: order 0,1,2,3,0 with 3-cycle spacing.
    step(1'b0, 4'b1111, 4'b0000);
    for (int g = 0; g < 5; g++) begin
      step(1'b1, 4'b1111, 4'b0000);
      check("t3_order", 32'(gnt_id), 32'(g % N_REQ));
      check("t3_vld", 32'(gnt_vld), 32'(1));
      step(1'b1, 4'b1111, 4'b1111);
      step(1'b1, 4'b1111, 4'b0000);
      check("t3_gap", 32'(gnt_vld), 32'(0));
    end

    // Hold limit: requester 0 never releases.
    step(1'b0, 4'b0000, 4'b0000);
    step(1'b1, 4'b0001, 4'b0000);
    for (int c = 1; c < MAX_HOLD; c++) begin
      step(1'b1, 4'b0001, 4'b0000);
      check("t4_held", 32'(gnt), 32'h1);
    end
    step(1'b1, 4'b0001, 4'b0000);
    check("t4_drop", 32'(gnt), 32'(0));
    check("t4_timeout", 32'(timeout), 32'(1));
    step(1'b1, 4'b0001, 4'b0000);
    check("t4_pulse_end", 32'(timeout), 32'(0));
    step(1'b1, 4'b0001, 4'b0000);
    check("t4_regrant", 32'(gnt), 32'h1);

    // done on the limit cycle wins over timeout; foreign done ignored.
    step(1'b0, 4'b0000, 4'b0000);
    step(1'b1, 4'b0010, 4'b0000);
    for (int c = 1; c < MAX_HOLD; c++) begin
      step(1'b1, 4'b0010, 4'b1000);
      check("t5_foreign_done", 32'(gnt), 32'h2);
    end
    step(1'b1, 4'b0010, 4'b0010);
    check("t5_release", 32'(gnt), 32'(0));
    check("t5_no_timeout", 32'(timeout), 32'(0));
    step(1'b1, 4'b0000, 4'b0000);
    check("t5_no_timeout_late", 32'(timeout), 32'(0));

    // Reset in the middle of a grant, then pointer back at 0.
    step(1'b1, 4'b0100, 4'b0000);
    step(1'b1, 4'b0100, 4'b0000);
    step(1'b0, 4'b0100, 4'b0000);
    check("t6_rst_gnt", 32'(gnt), 32'(0));
    check("t6_rst_timeout", 32'(timeout), 32'(0));
    step(1'b1, 4'b1111, 4'b0000);
    check("t6_ptr0", 32'(gnt_id), 32'd0);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 10000; c++) begin
      r_rand  = ($urandom_range(0, 199) != 0);
      rq_rand = 4'($urandom);
      dn_rand = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      step(r_rand, rq_rand, dn_rand);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
